// File: rtl/mvm_pkt_pkg.sv
// Shared types and tuser field layout for the MVM stream packetizer.
package mvm_pkt_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

  // tuser layout: RF address at the bottom, op code directly above it, rest zero.
  localparam int unsigned TuserAddrLsb = 0;

  function automatic int unsigned tuser_op_lsb(input int unsigned rfaddrw);
    return TuserAddrLsb + rfaddrw;
  endfunction

endpackage

// File: rtl/mvm_stream_packetizer_if.sv
// AXI-Stream transmit bundle used between the packetizer and its output stage.
interface mvm_stream_packetizer_if #(
  parameter int unsigned DATAW = 128,
  parameter int unsigned BYTEW = 8,
  parameter int unsigned IDW   = 32,
  parameter int unsigned DESTW = 12,
  parameter int unsigned USERW = 75
);

  logic             tvalid;
  logic             tready;
  logic [DATAW-1:0] tdata;
  logic [BYTEW-1:0] tstrb;
  logic [BYTEW-1:0] tkeep;
  logic             tlast;
  logic [IDW-1:0]   tid;
  logic [DESTW-1:0] tdest;
  logic [USERW-1:0] tuser;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );

endinterface

// File: rtl/mvm_pkt_out_reg.sv
// Single-entry AXI-Stream output register; holds its beat until the sink accepts it.
module mvm_pkt_out_reg #(
  parameter int unsigned DATAW = 128,
  parameter int unsigned BYTEW = 8,
  parameter int unsigned IDW   = 32,
  parameter int unsigned DESTW = 12,
  parameter int unsigned USERW = 75
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DATAW-1:0]        data,
  input  logic                    last,
  input  logic [IDW-1:0]          id,
  input  logic [DESTW-1:0]        dest,
  input  logic [USERW-1:0]        user,
  mvm_stream_packetizer_if.master tx
);

  logic             valid_q;
  logic [DATAW-1:0] data_q;
  logic             last_q;
  logic [IDW-1:0]   id_q;
  logic [DESTW-1:0] dest_q;
  logic [USERW-1:0] user_q;

  // The caller only asserts load when the slot is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
      dest_q  <= '0;
      user_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data;
      last_q  <= last;
      id_q    <= id;
      dest_q  <= dest;
      user_q  <= user;
    end else if (tx.tready) begin
      valid_q <= 1'b0;
    end
  end

  assign tx.tvalid = valid_q;
  assign tx.tdata  = data_q;
  assign tx.tlast  = last_q;
  assign tx.tid    = id_q;
  assign tx.tdest  = dest_q;
  assign tx.tuser  = user_q;
  assign tx.tstrb  = {BYTEW{valid_q}};
  assign tx.tkeep  = {BYTEW{valid_q}};

endmodule

// File: rtl/mvm_stream_packetizer.sv
// Packs a command plus payload beats into an AXI-Stream packet for an MVM register file.
// Define MVM_PKT_ADDR_INC_EN to step the RF address per beat; otherwise every beat uses cmd_addr.
module mvm_stream_packetizer
  import mvm_pkt_pkg::*;
#(
  parameter int unsigned DATAW     = 128,
  parameter int unsigned BYTEW     = 8,
  parameter int unsigned IDW       = 32,
  parameter int unsigned DESTW     = 12,
  parameter int unsigned USERW     = 75,
  parameter int unsigned RFADDRW   = 7,
  parameter int unsigned AXIS_OPSW = 2,
  parameter int unsigned MAXLEN    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [DESTW-1:0]           cmd_dest,
  input  logic [AXIS_OPSW-1:0]       cmd_op,
  input  logic [RFADDRW-1:0]         cmd_addr,
  input  logic [$clog2(MAXLEN):0]    cmd_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATAW-1:0]           in_data,
  output logic                       axis_tx_tvalid,
  input  logic                       axis_tx_tready,
  output logic [DATAW-1:0]           axis_tx_tdata,
  output logic [BYTEW-1:0]           axis_tx_tstrb,
  output logic [BYTEW-1:0]           axis_tx_tkeep,
  output logic                       axis_tx_tlast,
  output logic [IDW-1:0]             axis_tx_tid,
  output logic [DESTW-1:0]           axis_tx_tdest,
  output logic [USERW-1:0]           axis_tx_tuser
);

  localparam int unsigned LenW  = $clog2(MAXLEN) + 1;
  localparam int unsigned OpLsb = tuser_op_lsb(RFADDRW);

  state_e               state_q, state_d;
  logic [DESTW-1:0]     dest_q, dest_d;
  logic [AXIS_OPSW-1:0] op_q, op_d;
  logic [RFADDRW-1:0]   addr_q, addr_d;
  logic [LenW-1:0]      remain_q, remain_d;
  logic [IDW-1:0]       tid_q, tid_d;

  logic [LenW-1:0]      len_clamped;
  logic [USERW-1:0]     beat_user;
  logic                 cmd_fire;
  logic                 in_fire;

  mvm_stream_packetizer_if #(
    .DATAW (DATAW),
    .BYTEW (BYTEW),
    .IDW   (IDW),
    .DESTW (DESTW),
    .USERW (USERW)
  ) tx_if ();

  assign len_clamped = (cmd_len > LenW'(MAXLEN)) ? LenW'(MAXLEN) : cmd_len;

  assign cmd_ready = !rst && (state_q == StIdle);
  assign in_ready  = !rst && (state_q == StStream) && (!tx_if.tvalid || axis_tx_tready);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    beat_user = '0;
    beat_user[TuserAddrLsb +: RFADDRW] = addr_q;
    beat_user[OpLsb +: AXIS_OPSW]      = op_q;
  end

  // tid_q names the packet being loaded; it advances once its last beat enters the output stage.
  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    op_d     = op_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    tid_d    = tid_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          dest_d   = cmd_dest;
          op_d     = cmd_op;
          addr_d   = cmd_addr;
          remain_d = len_clamped;
          if (len_clamped != '0) begin
            state_d = StStream;
          end
        end
      end
      StStream: begin
        if (in_fire) begin
          remain_d = remain_q - LenW'(1);
`ifdef MVM_PKT_ADDR_INC_EN
          addr_d   = addr_q + RFADDRW'(1);
`else
          addr_d   = addr_q;
`endif
          if (remain_q == LenW'(1)) begin
            state_d = StIdle;
            tid_d   = tid_q + IDW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      dest_q   <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      tid_q    <= '0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      tid_q    <= tid_d;
    end
  end

  mvm_pkt_out_reg #(
    .DATAW (DATAW),
    .BYTEW (BYTEW),
    .IDW   (IDW),
    .DESTW (DESTW),
    .USERW (USERW)
  ) u_out_reg (
    .clk  (clk),
    .rst  (rst),
    .load (in_fire),
    .data (in_data),
    .last (remain_q == LenW'(1)),
    .id   (tid_q),
    .dest (dest_q),
    .user (beat_user),
    .tx   (tx_if)
  );

  assign tx_if.tready   = axis_tx_tready;
  assign axis_tx_tvalid = tx_if.tvalid;
  assign axis_tx_tdata  = tx_if.tdata;
  assign axis_tx_tstrb  = tx_if.tstrb;
  assign axis_tx_tkeep  = tx_if.tkeep;
  assign axis_tx_tlast  = tx_if.tlast;
  assign axis_tx_tid    = tx_if.tid;
  assign axis_tx_tdest  = tx_if.tdest;
  assign axis_tx_tuser  = tx_if.tuser;

endmodule

// File: tb/tb_mvm_stream_packetizer.sv
// Scoreboard bench for mvm_stream_packetizer; expected RF addresses follow MVM_PKT_ADDR_INC_EN.
module tb_mvm_stream_packetizer;

  localparam int unsigned DATAW   = 128;
  localparam int unsigned BYTEW   = 8;
  localparam int unsigned IDW     = 32;
  localparam int unsigned DESTW   = 12;
  localparam int unsigned USERW   = 75;
  localparam int unsigned RFADDRW = 7;
  localparam int unsigned OPSW    = 2;
  localparam int unsigned MAXLEN  = 64;
  localparam int unsigned LENW    = 7;

  typedef struct {
    logic [DATAW-1:0] data;
    logic             last;
    logic [USERW-1:0] user;
    logic [DESTW-1:0] dest;
    logic [IDW-1:0]   id;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [DESTW-1:0]   cmd_dest;
  logic [OPSW-1:0]    cmd_op;
  logic [RFADDRW-1:0] cmd_addr;
  logic [LENW-1:0]    cmd_len;
  logic               in_valid;
  logic               in_ready;
  logic [DATAW-1:0]   in_data;

  mvm_stream_packetizer_if #(
    .DATAW (DATAW),
    .BYTEW (BYTEW),
    .IDW   (IDW),
    .DESTW (DESTW),
    .USERW (USERW)
  ) mon ();

  beat_t            exp_q[$];
  logic [DATAW-1:0] drv_q[$];
  int               checks = 0;
  int               errors = 0;
  int unsigned      tid_model = 0;
  int               cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mvm_stream_packetizer dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_dest       (cmd_dest),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .axis_tx_tvalid (mon.tvalid),
    .axis_tx_tready (mon.tready),
    .axis_tx_tdata  (mon.tdata),
    .axis_tx_tstrb  (mon.tstrb),
    .axis_tx_tkeep  (mon.tkeep),
    .axis_tx_tlast  (mon.tlast),
    .axis_tx_tid    (mon.tid),
    .axis_tx_tdest  (mon.tdest),
    .axis_tx_tuser  (mon.tuser)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; mon.tready = 1'b0;
    cmd_dest = '0; cmd_op = '0; cmd_addr = '0; cmd_len = '0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tid_model = 0;
    exp_q.delete();
    drv_q.delete();
    @(negedge clk);
  endtask

  // Issues one command, streams its payload and scoreboards every transferred beat.
  task automatic run_pkt(input logic [DESTW-1:0] dest, input logic [OPSW-1:0] op,
                         input logic [RFADDRW-1:0] addr, input logic [LENW-1:0] len,
                         input bit toggle, output int first_load, output int last_xfer);
    int n, sent, got, budget;
    bit stalled;
    beat_t b, held;
    logic [RFADDRW-1:0] a;
    n = (len > LENW'(MAXLEN)) ? MAXLEN : int'(len);
    for (int k = 0; k < n; k++) begin
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.last = (k == n - 1);
`ifdef MVM_PKT_ADDR_INC_EN
      a = addr + RFADDRW'(k);
`else
      a = addr;
`endif
      b.user = '0;
      b.user[RFADDRW-1:0] = a;
      b.user[RFADDRW +: OPSW] = op;
      b.dest = dest;
      b.id = IDW'(tid_model);
      exp_q.push_back(b);
      drv_q.push_back(b.data);
    end
    if (n > 0) tid_model++;
    cmd_valid = 1'b1; cmd_dest = dest; cmd_op = op; cmd_addr = addr; cmd_len = len;
    #1;
    budget = 0;
    while (!cmd_ready && budget < 50) begin
      @(negedge clk); #1; budget++;
    end
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    if (cmd_ready !== 1'b1) errors++;
    @(negedge clk);
    cmd_valid = 1'b0;
    sent = 0; got = 0; budget = 0; stalled = 0; first_load = -1; last_xfer = -1;
    held = b;
    while (got < n && budget < 4 * n + 20) begin
      mon.tready = toggle ? (budget % 2 == 0) : 1'b1;
      in_valid = (drv_q.size() > 0);
      in_data = in_valid ? drv_q[0] : '0;
      #1;
      if (stalled) begin
        checks++;
        if (mon.tvalid !== 1'b1 || mon.tdata !== held.data || mon.tlast !== held.last ||
            mon.tuser !== held.user || mon.tid !== held.id) begin
          errors++;
          $display("FAIL stall_hold: tdata=%h tlast=%b required %h %b", mon.tdata, mon.tlast,
                   held.data, held.last);
        end
      end
      if (sent < n) begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++; $display("FAIL cmd_ready_stream: cmd_ready=%b required 0", cmd_ready);
        end
      end
      stalled = 0;
      if (mon.tvalid === 1'b1 && !mon.tready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL in_ready_stall: in_ready=%b required 0", in_ready);
        end
        stalled = 1;
        held.data = mon.tdata; held.last = mon.tlast; held.user = mon.tuser; held.id = mon.tid;
      end
      if (mon.tvalid === 1'b1 && mon.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_beat: tdata=%h required no beat", mon.tdata);
        end else begin
          b = exp_q.pop_front();
          if (mon.tdata !== b.data || mon.tlast !== b.last || mon.tuser !== b.user ||
              mon.tdest !== b.dest || mon.tid !== b.id || mon.tstrb !== '1 ||
              mon.tkeep !== '1) begin
            errors++;
            $display("FAIL beat%0d: data=%h last=%b user=%h dest=%h id=%0d strb=%h keep=%h required data=%h last=%b user=%h dest=%h id=%0d strb/keep=ff",
                     got, mon.tdata, mon.tlast, mon.tuser, mon.tdest, mon.tid, mon.tstrb,
                     mon.tkeep, b.data, b.last, b.user, b.dest, b.id);
          end
        end
        got++;
        last_xfer = cyc;
      end
      if (in_valid && in_ready === 1'b1) begin
        if (first_load < 0) first_load = cyc;
        void'(drv_q.pop_front());
        sent++;
      end
      budget++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    mon.tready = 1'b1;
    if (got < n) begin
      checks++; errors++;
      $display("FAIL pkt_timeout: beats=%0d required %0d", got, n);
      exp_q.delete(); drv_q.delete();
    end
    #1;
    checks++;
    if (mon.tvalid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL pkt_end: tvalid=%b cmd_ready=%b required 0 1", mon.tvalid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; mon.tready = 1'b1;
    cmd_dest = '0; cmd_op = '0; cmd_addr = '0; cmd_len = '0; in_data = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mon.tvalid !== 1'b0 || mon.tlast !== 1'b0 || mon.tdata !== '0 || mon.tuser !== '0 ||
        mon.tdest !== '0 || mon.tid !== '0 || cmd_ready !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tvalid=%b tlast=%b cmd_ready=%b in_ready=%b required all 0",
               mon.tvalid, mon.tlast, cmd_ready, in_ready);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    int f, l;
    do_reset();
    run_pkt(12'd5, 2'd1, 7'd3, 7'd4, 1'b0, f, l);
    checks++;
    if (l - f != 4) begin
      errors++; $display("FAIL basic_latency: span=%0d required 4", l - f);
    end
  endtask

  task automatic test_backpressure();
    int f, l;
    do_reset();
    run_pkt(12'd9, 2'd2, 7'd10, 7'd8, 1'b1, f, l);
  endtask

  task automatic test_addr_wrap();
    int f, l;
    do_reset();
    run_pkt(12'd7, 2'd3, 7'd126, 7'd4, 1'b0, f, l);
  endtask

  task automatic test_len_zero();
    int f, l;
    do_reset();
    run_pkt(12'd1, 2'd0, 7'd20, 7'd0, 1'b0, f, l);
    run_pkt(12'd2, 2'd1, 7'd21, 7'd1, 1'b0, f, l);
  endtask

  task automatic test_clamp();
    int f, l;
    do_reset();
    run_pkt(12'hABC, 2'd2, 7'd100, 7'd100, 1'b0, f, l);
  endtask

  task automatic test_reset_midpacket();
    int f, l, got, budget;
    do_reset();
    cmd_valid = 1'b1; cmd_dest = 12'd3; cmd_op = 2'd1; cmd_addr = 7'd40; cmd_len = 7'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 0; budget = 0;
    while (got < 2 && budget < 20) begin
      mon.tready = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (mon.tvalid === 1'b1) begin
        got++;
        checks++;
        if (mon.tlast !== 1'b0) begin
          errors++; $display("FAIL mid_tlast: tlast=%b required 0", mon.tlast);
        end
      end
      budget++;
      if (got < 2) @(negedge clk);
    end
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (mon.tvalid !== 1'b0 || mon.tlast !== 1'b0 || mon.tdata !== '0 || mon.tid !== '0 ||
        in_ready !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tvalid=%b tlast=%b in_ready=%b cmd_ready=%b required all 0",
               mon.tvalid, mon.tlast, in_ready, cmd_ready);
    end
    rst = 1'b0; tid_model = 0;
    @(negedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_release: cmd_ready=%b required 1", cmd_ready);
    end
    run_pkt(12'd4, 2'd0, 7'd8, 7'd2, 1'b0, f, l);
  endtask

  task automatic test_back_to_back();
    int f, l;
    do_reset();
    run_pkt(12'd11, 2'd1, 7'd0, 7'd3, 1'b0, f, l);
    run_pkt(12'd12, 2'd2, 7'd50, 7'd2, 1'b1, f, l);
    run_pkt(12'd13, 2'd3, 7'd90, 7'd5, 1'b0, f, l);
    checks++;
    if (tid_model != 3) begin
      errors++; $display("FAIL b2b_count: packets=%0d required 3", tid_model);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_addr_wrap();
    test_len_zero();
    test_clamp();
    test_reset_midpacket();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mvm_stream_packetizer.md
MVM_STREAM_PACKETIZER -- requirements
Module: mvm_stream_packetizer

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATAW 128 beat width; BYTEW 8 strobe width; IDW 32 tid width; DESTW 12 tdest width; USERW 75 tuser width; RFADDRW 7 register-file address width; AXIS_OPSW 2 op-code width; MAXLEN 64 max beats per packet.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: reset, synchronous and active-high.
- cmd_valid, in, 1: command handshake valid.
- cmd_ready, out, 1: command handshake ready.
- cmd_dest, in, DESTW: packet destination.
- cmd_op, in, AXIS_OPSW: MVM op code.
- cmd_addr, in, RFADDRW: start RF address.
- cmd_len, in, $clog2(MAXLEN)+1: beat count.
- in_valid, in, 1: payload handshake valid.
- in_ready, out, 1: payload handshake ready.
- in_data, in, DATAW: payload beat.
- axis_tx_tvalid, out, 1: AXI-Stream master valid.
- axis_tx_tready, in, 1: AXI-Stream master ready.
- axis_tx_tdata, out, DATAW: stream data.
- axis_tx_tstrb, out, BYTEW: byte strobes.
- axis_tx_tkeep, out, BYTEW: byte keeps.
- axis_tx_tlast, out, 1: last beat of packet.
- axis_tx_tid, out, IDW: packet sequence id.
- axis_tx_tdest, out, DESTW: destination.
- axis_tx_tuser, out, USERW: op and RF address.

Function
REQ-003 SHALL implement FSM IDLE/STREAM; cmd_ready=1 only in IDLE; cmd handshake latches dest, op, addr, len and loads beat counter.
REQ-004 SHALL go IDLE->STREAM on cmd handshake with len>=1; len=0 SHALL be accepted, emit no beats, stay IDLE, leave tid unchanged.
REQ-005 SHALL drive in_ready = (state==STREAM) && (!axis_tx_tvalid || axis_tx_tready); payload SHALL flow only then.
REQ-006 SHALL register every accepted payload beat into the output stage: 1-cycle latency in_data->axis_tx_tdata, sustained 1 beat/cycle.
REQ-007 SHALL hold all axis_tx_* outputs stable while tvalid=1 and tready=0 (AXI-Stream rule); tvalid SHALL NOT depend on tready.
REQ-008 SHALL assert tlast on beat number len (1-based) only; after that beat is loaded, FSM SHALL return to IDLE (one-cycle bubble before next cmd_ready).
REQ-009 SHALL set tuser[RFADDRW-1:0] = beat RF address, tuser[RFADDRW+AXIS_OPSW-1:RFADDRW] = op, remaining tuser bits 0; tdest = latched dest for every beat.
REQ-010 SHALL drive tstrb and tkeep all-ones whenever tvalid=1.
REQ-011 SHALL drive tid = packet sequence counter, constant within a packet, incremented after each tlast transfer, wrapping modulo 2^IDW.
REQ-012 SHALL compute RF address modulo 2^RFADDRW (wrap 127->0 at default width).
REQ-013 SHALL clamp cmd_len>MAXLEN to MAXLEN.

Reset
REQ-014 SHALL, while rst=1 (even mid-packet), force FSM IDLE, tvalid=0, tlast=0, tdata/tuser/tdest=0, beat counter=0, tid counter=0, in_ready=0, cmd_ready=0; the partial packet SHALL be discarded with no tlast emitted.
REQ-015 SHALL raise cmd_ready in the first cycle after rst deasserts.

Configuration
REQ-016 SHALL, with MVM_PKT_ADDR_INC_EN defined, give beat k (0-based) RF address cmd_addr+k; without it, every beat SHALL carry cmd_addr.

Structure
REQ-017 SHALL place the FSM state enum and tuser field offset/width constants in package mvm_pkt_pkg.
REQ-018 SHALL isolate the output register and handshake in sub-module mvm_pkt_out_reg, instantiated once.

Verification
REQ-019 SHALL test cmd(dest=5,op=1,addr=3,len=4) with 4 beats and tready=1: 4 back-to-back beats, tlast on 4th only, tuser addr 3,4,5,6 (macro on) or 3,3,3,3 (macro off), tid=0.
REQ-020 SHALL test tready toggling 1/0 every cycle on a len=8 packet: all 8 beats delivered in order with outputs stable during stalls, and in_ready=0 in stall cycles.
REQ-021 SHALL test addr=126, len=4 with the macro on: addresses 126, 127, 0, 1.
REQ-022 SHALL test len=0 followed by len=1: no output for the first command; one beat with tlast=1 and tid=0 for the second.
REQ-023 SHALL test rst asserted after beat 2 of a len=6 packet: tvalid=0 the next cycle; a new len=2 packet then carries tid=0 and correct tlast.
REQ-024 SHALL test three consecutive packets: tid values 0, 1, 2, and cmd_ready=0 throughout each STREAM phase.
